// File: rtl/sram_addr_pkg.sv
// Shared constants for the multi-channel SRAM address generator.
// The helper derives the channel-index width so that a single channel still gets one bit.
package sram_addr_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ADDR_W = 26;
  localparam int DEF_CNT_W  = 13;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_addr_chan.sv
// One address channel: config registers, column/row counters, row-offset accumulator and done flag.
// Presents the address and last flags for its current position; the top decides when to advance.
module sram_addr_chan
  import sram_addr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_row_len,
  input  logic [CNT_W-1:0]  cfg_num_rows,
  input  logic [ADDR_W-1:0] cfg_pitch,
  input  logic              cfg_mode,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last_row,
  output logic              last_frame,
  output logic              active,
  output logic              done
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] pitch;
  logic [CNT_W-1:0]  row_len;
  logic [CNT_W-1:0]  num_rows;
  logic              mode;
  logic [CNT_W-1:0]  col;
  logic [CNT_W-1:0]  row;
  logic [ADDR_W-1:0] row_off;

  // A zero-length row or zero-row frame leaves the channel disabled; done blocks further walks.
  assign active     = (row_len != '0) && (num_rows != '0) && !done;
  assign last_row   = (col == row_len - CNT_W'(1));
  assign last_frame = last_row && (row == num_rows - CNT_W'(1));
  assign addr       = base + row_off + ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= '0;
      pitch    <= '0;
      row_len  <= '0;
      num_rows <= '0;
      mode     <= MODE_WRAP;
      col      <= '0;
      row      <= '0;
      row_off  <= '0;
      done     <= 1'b0;
    end else if (load) begin
      base     <= cfg_base;
      pitch    <= cfg_pitch;
      row_len  <= cfg_row_len;
      num_rows <= cfg_num_rows;
      mode     <= cfg_mode;
      col      <= '0;
      row      <= '0;
      row_off  <= '0;
      done     <= 1'b0;
    end else if (clear) begin
      col     <= '0;
      row     <= '0;
      row_off <= '0;
      done    <= 1'b0;
    end else if (adv) begin
      if (last_frame) begin
        // One-shot keeps its final position so the flags stay meaningful while done.
        if (mode == MODE_ONESHOT) begin
          done <= 1'b1;
        end else begin
          col     <= '0;
          row     <= '0;
          row_off <= '0;
        end
      end else if (last_row) begin
        col     <= '0;
        row     <= row + CNT_W'(1);
        row_off <= row_off + pitch;
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_addr_gen.sv
// Multi-channel SRAM address generator: request decode to NUM_CH channel walkers,
// a single registered valid/ready output port and a one-cycle error pulse for rejected requests.
module sram_addr_gen
  import sram_addr_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_row_len,
  input  logic [CNT_W-1:0]  cfg_num_rows,
  input  logic [ADDR_W-1:0] cfg_pitch,
  input  logic              cfg_mode,
  input  logic              req,
  input  logic [CH_W-1:0]   req_ch,
  output logic              req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last_row,
  output logic              out_last_frame,
  output logic              err,
  output logic [NUM_CH-1:0] ch_done
);

  logic [NUM_CH-1:0] ch_active;
  logic [NUM_CH-1:0] ch_last_row;
  logic [NUM_CH-1:0] ch_last_frame;
  logic [ADDR_W-1:0] ch_addr [NUM_CH];

  logic              sel_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_last_row;
  logic              sel_last_frame;
  logic              fire;
  logic              accept;
  logic              reject;
  logic              last_row_q;
  logic              last_frame_q;

  assign req_ready = (!out_valid || out_ready) && !clear && !(cfg_we && (cfg_ch == req_ch));
  assign fire      = req && req_ready;
  assign accept    = fire && sel_ok;
  assign reject    = fire && !sel_ok;

  // Loop decode so an out-of-range req_ch simply matches nothing and is rejected.
  always_comb begin
    sel_ok         = 1'b0;
    sel_addr       = '0;
    sel_last_row   = 1'b0;
    sel_last_frame = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_ch == CH_W'(i)) begin
        sel_ok         = ch_active[i];
        sel_addr       = ch_addr[i];
        sel_last_row   = ch_last_row[i];
        sel_last_frame = ch_last_frame[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    sram_addr_chan #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .load        (cfg_we && (cfg_ch == CH_W'(g))),
      .cfg_base    (cfg_base),
      .cfg_row_len (cfg_row_len),
      .cfg_num_rows(cfg_num_rows),
      .cfg_pitch   (cfg_pitch),
      .cfg_mode    (cfg_mode),
      .adv         (accept && (req_ch == CH_W'(g))),
      .addr        (ch_addr[g]),
      .last_row    (ch_last_row[g]),
      .last_frame  (ch_last_frame[g]),
      .active      (ch_active[g]),
      .done        (ch_done[g])
    );
  end

  assign out_last_row   = out_valid && last_row_q;
  assign out_last_frame = out_valid && last_frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_ch       <= '0;
      last_row_q   <= 1'b0;
      last_frame_q <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= reject;
      if (clear) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        out_addr     <= sel_addr;
        out_ch       <= req_ch;
        last_row_q   <= sel_last_row;
        last_frame_q <= sel_last_frame;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
